fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side drain engine for the async FIFO.
- Sits in the read clock domain and pops words through the FIFO read port (RINC/RDATA/REMPTY/AREMPTY).
- Presents the words downstream as a valid/ready stream through a small output buffer.
- Provides enable/drain control, a busy flag and a delivered-word counter; sustains 1 word/clock.

Parameters:
DATASIZE, 8, word width; matches the FIFO word width
OBUF_DEPTH, 4, output buffer entries; power of two, minimum 3 for full throughput
CNTSIZE, 16, width of the delivered-word counter
FRAME_LEN, 16, words per frame; used only with FRAME_LAST_EN

Ports:
RCLK_I  in  1  read-domain clock
RRST_N_I  in  1  reset, synchronous, active-low
EN_I  in  1  1 = drain FIFO continuously; 0 = stop popping and flush buffer
FIFO_RDATA_I  in  DATASIZE  FIFO read data, valid the cycle after an accepted pop
FIFO_REMPTY_I  in  1  FIFO empty
FIFO_AREMPTY_I  in  1  FIFO almost empty (at most one word left)
FIFO_RINC_O  out  1  pop request to FIFO
M_DATA_O  out  DATASIZE  stream data (head of buffer)
M_VALID_O  out  1  stream valid
M_READY_I  in  1  stream ready
BUSY_O  out  1  state != IDLE
WCNT_O  out  CNTSIZE  words delivered (M_VALID_O & M_READY_I), wraps modulo 2^CNTSIZE

Behaviour:
- Single clock RCLK_I; reset synchronous active-low (RRST_N_I sampled on the rising edge).
- Reset values:
  - FIFO_RINC_O=0, M_VALID_O=0, M_DATA_O=0, BUSY_O=0, WCNT_O=0.
  - Buffer pointers and occupancy 0; inflight flag 0; state IDLE; frame counter 0.
- FSM:
  - IDLE: EN_I=1 -> RUN.
  - RUN: EN_I=0 -> DRAIN.
  - DRAIN: EN_I=1 -> RUN; else when occ=0 and inflight=0 -> IDLE.
- Pop rule (combinational): FIFO_RINC_O = (state==RUN) & !FIFO_REMPTY_I & (occ + inflight - pop_out < OBUF_DEPTH) & !(FIFO_AREMPTY_I & inflight).
  - pop_out = M_VALID_O & M_READY_I.
  - The last term prevents a double pop on the final word.
- Pipeline:
  - inflight <= FIFO_RINC_O each cycle.
  - When inflight=1, FIFO_RDATA_I is written into the buffer at the end of that cycle.
  - Latency: RINC in cycle t -> data captured end of t+1 -> M_VALID_O in t+2 (if buffer was empty).
- Stream rules:
  - M_VALID_O = (occ != 0).
  - M_DATA_O = buffer head; held stable while M_VALID_O & !M_READY_I.
  - Never drops or duplicates a word.
- Simultaneous capture and pop: occ unchanged; order preserved.
- Full buffer: no RINC issued; throughput recovers the cycle after a pop.
- Empty FIFO: no RINC; M_VALID_O falls once the buffer empties.
- DRAIN: no new pops, but an inflight word is still captured and delivered.
- Reset mid-operation: all state cleared next edge; buffered and inflight words are discarded.
- WCNT_O increments on every pop_out; wraps from 2^CNTSIZE-1 to 0.
- Occupancy arithmetic is log2(OBUF_DEPTH)+1 bits wide; pointers wrap modulo OBUF_DEPTH.

Optional Feature:
FRAME_LAST_EN
- Defined:
  - Adds port M_LAST_O (out, 1), which is 1 with the FRAME_LEN-th word of each frame.
  - Frame counter advances on pop_out and resets to 0 after the last word and on reset.
  - In DRAIN, the counter is not forced; a partial frame stays partial.
- Undefined: no M_LAST_O port and no frame counter.

Test Plan:
- Reset, then EN_I=1, FIFO holding 8 words 0x01..0x08, M_READY_I=1:
  - first RINC in the cycle after RUN is entered; M_VALID_O 2 cycles later;
  - 8 consecutive beats 0x01..0x08; WCNT_O=8; exactly 8 RINC pulses.
- Same 8 words with M_READY_I=0 for 10 cycles:
  - exactly OBUF_DEPTH (4) RINC pulses; M_DATA_O=0x01 held stable;
  - after ready, all 8 words arrive in order.
- FIFO with 1 word, FIFO_AREMPTY_I=1:
  - single RINC, no back-to-back second RINC; one beat; M_VALID_O then 0.
- EN_I dropped the cycle after a RINC with 2 words buffered:
  - no further RINC; 3 beats delivered; BUSY_O falls after the last beat; state IDLE.
- RRST_N_I=0 for one cycle with occ=3:
  - next cycle M_VALID_O=0, WCNT_O=0, BUSY_O=0, FIFO_RINC_O=0.
- FRAME_LAST_EN, FRAME_LEN=4, 10 words:
  - M_LAST_O high on beats 4 and 8 only;
  - WCNT_O wrap checked with CNTSIZE=3 (count 7 -> 0).

Source files
------------

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side async FIFO drain engine with valid/ready stream output
//
// Purpose:
//   Pops words from the read port of the async FIFO and presents them downstream
//   as a valid/ready stream through a small circular output buffer. Sustains one
//   word per clock when the consumer is always ready.
//
// Ports:
//   RCLK_I          read-domain clock
//   RRST_N_I        synchronous active-low reset
//   EN_I            1 = drain FIFO continuously, 0 = stop popping and flush buffer
//   FIFO_RDATA_I    FIFO read data, valid the cycle after an accepted pop
//   FIFO_REMPTY_I   FIFO empty
//   FIFO_AREMPTY_I  FIFO almost empty (at most one word left)
//   FIFO_RINC_O     pop request to the FIFO
//   M_DATA_O        stream data (buffer head)
//   M_VALID_O       stream valid
//   M_READY_I       stream ready
//   M_LAST_O        last word of a FRAME_LEN-word frame (only with FRAME_LAST_EN)
//   BUSY_O          engine not idle
//   WCNT_O          delivered-word counter, wraps modulo 2^CNTSIZE
//
// Optional feature macro: FRAME_LAST_EN adds M_LAST_O and a frame counter.

module fifo_rd_stream #(
  parameter int DATASIZE   = 8,
  parameter int OBUF_DEPTH = 4,
  parameter int CNTSIZE    = 16,
  parameter int FRAME_LEN  = 16
) (
  input  logic                RCLK_I,
  input  logic                RRST_N_I,
  input  logic                EN_I,
  input  logic [DATASIZE-1:0] FIFO_RDATA_I,
  input  logic                FIFO_REMPTY_I,
  input  logic                FIFO_AREMPTY_I,
  output logic                FIFO_RINC_O,
  output logic [DATASIZE-1:0] M_DATA_O,
  output logic                M_VALID_O,
  input  logic                M_READY_I,
`ifdef FRAME_LAST_EN
  output logic                M_LAST_O,
`endif
  output logic                BUSY_O,
  output logic [CNTSIZE-1:0]  WCNT_O
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW:0] DEPTH_L = OBUF_DEPTH[OW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATASIZE-1:0] r_buf [OBUF_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [OW-1:0]       r_occ;
  logic                r_inflight;
  logic [CNTSIZE-1:0]  r_wcnt;

  logic                w_pop_out;
  logic [OW:0]         w_level;
  logic                w_rinc;

  assign w_pop_out = M_VALID_O & M_READY_I;

  // Occupancy the buffer will hold after this edge, counting the word already
  // on its way from the FIFO. One extra bit so the sum never wraps.
  assign w_level = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight} - {{OW{1'b0}}, w_pop_out};

  // The AREMPTY term covers the empty flag lagging one pop: with one word left
  // and that word already in flight, a second pop would underflow the FIFO.
  assign w_rinc = (r_state == S_RUN) & ~FIFO_REMPTY_I & (w_level < DEPTH_L)
                & ~(FIFO_AREMPTY_I & r_inflight);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (EN_I) w_state_nxt = S_RUN;
      S_RUN:   if (!EN_I) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (EN_I) begin
          w_state_nxt = S_RUN;
        end else if ((r_occ == '0) && !r_inflight) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge RCLK_I) begin
    if (!RRST_N_I) begin
      r_state    <= S_IDLE;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_wcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rinc;
      r_occ      <= w_level[OW-1:0];
      if (r_inflight) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop_out) begin
        r_rptr <= r_rptr + PW'(1);
        r_wcnt <= r_wcnt + CNTSIZE'(1);
      end
    end
  end

  // Buffer storage is cleared on reset so the idle stream data reads as zero.
  always_ff @(posedge RCLK_I) begin
    if (!RRST_N_I) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (r_inflight) begin
      r_buf[r_wptr] <= FIFO_RDATA_I;
    end
  end

  assign FIFO_RINC_O = w_rinc;
  assign M_VALID_O   = (r_occ != '0);
  assign M_DATA_O    = r_buf[r_rptr];
  assign BUSY_O      = (r_state != S_IDLE);
  assign WCNT_O      = r_wcnt;

`ifdef FRAME_LAST_EN
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FRAME_LEN - 1);

  logic [FW-1:0] r_fcnt;
  logic          w_flast;

  assign w_flast  = (r_fcnt == FLAST);
  assign M_LAST_O = M_VALID_O & w_flast;

  // Advances only on delivered words; a drain leaves a partial frame partial.
  always_ff @(posedge RCLK_I) begin
    if (!RRST_N_I) begin
      r_fcnt <= '0;
    end else if (w_pop_out) begin
      r_fcnt <= w_flast ? '0 : r_fcnt + FW'(1);
    end
  end
`else
  logic w_unused_frame;
  assign w_unused_frame = (FRAME_LEN > 0);
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int FLEN  = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en;
  logic          ready;
  logic [DW-1:0] rdata = '0;
  logic          rempty;
  logic          arempty;
  logic          rinc;
  logic [DW-1:0] mdata;
  logic          valid;
  logic          busy;
  logic [CW-1:0] wcnt;
`ifdef FRAME_LAST_EN
  logic          last;
`endif

  fifo_rd_stream #(
    .DATASIZE   (DW),
    .OBUF_DEPTH (DEPTH),
    .CNTSIZE    (CW),
    .FRAME_LEN  (FLEN)
  ) dut (
    .RCLK_I         (clk),
    .RRST_N_I       (rst_n),
    .EN_I           (en),
    .FIFO_RDATA_I   (rdata),
    .FIFO_REMPTY_I  (rempty),
    .FIFO_AREMPTY_I (arempty),
    .FIFO_RINC_O    (rinc),
    .M_DATA_O       (mdata),
    .M_VALID_O      (valid),
    .M_READY_I      (ready),
`ifdef FRAME_LAST_EN
    .M_LAST_O       (last),
`endif
    .BUSY_O         (busy),
    .WCNT_O         (wcnt)
  );

  // FIFO read-port model; f_lag delays the empty flags by one clock.
  logic [DW-1:0] fmem [0:63];
  int            f_wr = 0;
  int            f_rd = 0;
  int            f_cnt_d = 0;
  int            f_under = 0;
  int            f_cnt;
  bit            f_flush = 1'b0;
  bit            f_lag = 1'b0;

  assign f_cnt   = f_wr - f_rd;
  assign rempty  = ((f_lag ? f_cnt_d : f_cnt) == 0);
  assign arempty = ((f_lag ? f_cnt_d : f_cnt) <= 1);

  always @(posedge clk) begin
    f_cnt_d <= f_cnt;
    if (f_flush) begin
      f_rd <= f_wr;
    end else if (rinc) begin
      if (f_cnt > 0) begin
        rdata <= fmem[f_rd % 64];
        f_rd  <= f_rd + 1;
      end else begin
        f_under <= f_under + 1;
      end
    end
  end

  typedef struct {
    int            nwords;
    int            stall;
    int            exp_rinc;
    logic [DW-1:0] base;
  } vec_t;

  vec_t          vecs [5];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_rinc = 0;
  int            n_beats = 0;
  int            n_last = 0;
  logic [CW-1:0] m_wcnt = '0;
  int            m_fpos = 0;
  bit            mon_on = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: observe at the falling edge, return 1ns after the rising edge.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    if (mon_on) begin
      if (rinc) n_rinc++;
      check("wcnt_track", wcnt, m_wcnt);
      if (hold_prev && valid) check("hold_data", mdata, prev_data);
      if (!rst_n) begin
        m_wcnt = '0;
        m_fpos = 0;
        exp_q.delete();
      end else if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", mdata, e);
        end
`ifdef FRAME_LAST_EN
        check("last_flag", last, (m_fpos == FLEN - 1));
        if (last) n_last++;
`endif
        m_fpos = (m_fpos == FLEN - 1) ? 0 : m_fpos + 1;
        m_wcnt = m_wcnt + 1'b1;
        n_beats++;
      end
      hold_prev = rst_n && valid && !ready;
      prev_data = mdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[f_wr % 64] = base + DW'(i);
      exp_q.push_back(base + DW'(i));
      f_wr++;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    f_flush = 1'b1;
    tick();
    rst_n   = 1'b1;
    f_flush = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string name);
    int budget = 300;
    while (n_beats < target && budget > 0) begin
      tick();
      budget--;
    end
    check(name, n_beats, target);
  endtask

  task automatic wait_idle(input string name);
    int budget = 30;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    check(name, busy, 0);
  endtask

  initial begin
    int r0;
    int b0;

    vecs[0] = '{nwords: 8, stall: 10, exp_rinc: 4, base: 8'h01};
    vecs[1] = '{nwords: 3, stall: 10, exp_rinc: 3, base: 8'h40};
    vecs[2] = '{nwords: 1, stall: 10, exp_rinc: 1, base: 8'hA0};
    vecs[3] = '{nwords: 5, stall: 8,  exp_rinc: 4, base: 8'h10};
    vecs[4] = '{nwords: 4, stall: 10, exp_rinc: 4, base: 8'hC0};

    rst_n = 1'b0;
    en    = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    mon_on = 1'b1;
    check("rst_rinc", rinc, 0);
    check("rst_valid", valid, 0);
    check("rst_data", mdata, 0);
    check("rst_busy", busy, 0);
    check("rst_wcnt", wcnt, 0);

    // Latency and full-rate drain of 8 words
    load(8, 8'h01);
    ready = 1'b1;
    r0 = n_rinc;
    b0 = n_beats;
    en = 1'b1;
    check("idle_no_rinc", rinc, 0);
    tick();
    check("first_rinc", rinc, 1);
    check("busy_run", busy, 1);
    check("valid_t1", valid, 0);
    tick();
    check("valid_t2", valid, 0);
    tick();
    check("valid_t3", valid, 1);
    check("first_data", mdata, 8'h01);
    wait_beats(b0 + 8, "drain8_beats");
    tick();
    tick();
    check("drain8_rinc", n_rinc - r0, 8);
    check("drain8_wcnt_wrap", wcnt, 0);
    check("drain8_valid_low", valid, 0);
    en = 1'b0;
    wait_idle("drain8_idle");

    // Table: stalled consumer, then release
    for (int v = 0; v < 5; v++) begin
      do_reset();
      load(vecs[v].nwords, vecs[v].base);
      ready = 1'b0;
      r0 = n_rinc;
      b0 = n_beats;
      en = 1'b1;
      for (int c = 0; c < vecs[v].stall; c++) tick();
      check("stall_rinc", n_rinc - r0, vecs[v].exp_rinc);
      check("stall_valid", valid, 1);
      check("stall_data", mdata, vecs[v].base);
      ready = 1'b1;
      wait_beats(b0 + vecs[v].nwords, "tbl_beats");
      tick();
      tick();
      check("tbl_rinc", n_rinc - r0, vecs[v].nwords);
      check("tbl_valid_low", valid, 0);
      check("tbl_sb_empty", exp_q.size(), 0);
      en = 1'b0;
      wait_idle("tbl_idle");
    end

    // Single word with a lagging empty flag: no second pop
    do_reset();
    f_lag = 1'b1;
    load(1, 8'h5A);
    tick();
    tick();
    ready = 1'b1;
    r0 = n_rinc;
    b0 = n_beats;
    en = 1'b1;
    tick();
    check("one_rinc", rinc, 1);
    tick();
    check("no_double_pop", rinc, 0);
    wait_beats(b0 + 1, "one_beat");
    tick();
    check("one_valid_low", valid, 0);
    check("one_rinc_total", n_rinc - r0, 1);
    en = 1'b0;
    wait_idle("one_idle");
    f_lag = 1'b0;

    // Enable dropped with two words buffered and one in flight
    do_reset();
    load(8, 8'h20);
    ready = 1'b0;
    r0 = n_rinc;
    b0 = n_beats;
    en = 1'b1;
    tick();
    tick();
    tick();
    check("third_rinc", rinc, 1);
    en = 1'b0;
    tick();
    check("drain_no_rinc", rinc, 0);
    check("drain_busy", busy, 1);
    tick();
    tick();
    check("drain_rinc_total", n_rinc - r0, 3);
    check("drain_data", mdata, 8'h20);
    ready = 1'b1;
    wait_beats(b0 + 3, "drain_beats");
    check("busy_after_last", busy, 1);
    tick();
    check("drain_idle", busy, 0);
    check("drain_valid_low", valid, 0);
    check("drain_rinc_final", n_rinc - r0, 3);

    // Reset with three words buffered; leftover FIFO words are pending in the scoreboard
    ready = 1'b0;
    r0 = n_rinc;
    en = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", valid, 1);
    check("pre_rst_data", mdata, 8'h23);
    check("pre_rst_wcnt", wcnt, 3);
    en = 1'b1;
    do_reset();
    check("mid_rst_valid", valid, 0);
    check("mid_rst_wcnt", wcnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rinc", rinc, 0);
    check("mid_rst_data", mdata, 0);
    en = 1'b0;
    tick();

`ifdef FRAME_LAST_EN
    // Frames of FLEN words over 10 words
    do_reset();
    load(10, 8'h60);
    ready = 1'b1;
    b0 = n_beats;
    r0 = n_last;
    en = 1'b1;
    wait_beats(b0 + 10, "frame_beats");
    check("frame_last_count", n_last - r0, 2);
    check("frame_wcnt", wcnt, 10 % 8);
    en = 1'b0;
    wait_idle("frame_idle");
`endif

    check("fifo_underflow", f_under, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
